// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - single-entry instruction fetch responder with wait states and loader port
module imem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_imem,
    output logic [XLEN-1:0] instr_imem,
    output logic            stall_imem,
    output logic            imem_fault,
    input  logic            load_en,
    input  logic [XLEN-1:0] load_addr,
    input  logic [XLEN-1:0] load_data
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // The miss cycle itself is the first stalled cycle, so BUSY holds one cycle fewer than WAIT_STATES+1.
    localparam logic [3:0] WS_START = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          fsm;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] instr_q;
    logic            valid_q;
    logic            fault_q;
    logic [3:0]      wait_cnt;

    logic [31:0] mem [DEPTH_WORDS];

    logic             hit;
    logic             same_req;
    logic             capture;
    logic             load_ok;
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] load_idx;

    function automatic logic addr_ok(input logic [XLEN-1:0] a);
        return (a[1:0] == 2'b00) && ((a >> (IDX_W + 2)) == '0);
    endfunction

    always_comb begin
        hit      = valid_q && (pc_imem == addr_q);
        same_req = (pc_imem == req_addr);
        capture  = ((fsm == IDLE) && !hit && (WAIT_STATES == 0)) ||
                   ((fsm == BUSY) && same_req && (wait_cnt == 4'd0));
        load_ok  = load_en && addr_ok(load_addr);
        pc_idx   = pc_imem[IDX_W+1:2];
        load_idx = load_addr[IDX_W+1:2];
    end

    assign stall_imem = !rst && ((fsm == BUSY) || !hit);
    assign instr_imem = instr_q;
    assign imem_fault = fault_q;

    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_idx] <= load_data[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm      <= IDLE;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            req_addr <= '0;
            wait_cnt <= 4'd0;
            instr_q  <= NOP;
            fault_q  <= 1'b0;
        end else begin
            if (capture) begin
                fsm     <= IDLE;
                addr_q  <= pc_imem;
                valid_q <= 1'b1;
                if (addr_ok(pc_imem)) begin
                    instr_q <= XLEN'(mem[pc_idx]);
                    fault_q <= 1'b0;
                end else begin
                    instr_q <= NOP;
                    fault_q <= 1'b1;
                end
            end else if (fsm == IDLE) begin
                if (!hit) begin
                    fsm      <= BUSY;
                    wait_cnt <= WS_START;
                    req_addr <= pc_imem;
                end
            end else if (!same_req) begin
                req_addr <= pc_imem;
                wait_cnt <= WS_START;
            end else begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            // A loader write to the cached or in-flight word overrides any capture on this edge.
            if (load_ok) begin
                if (load_addr[XLEN-1:2] == (capture ? pc_imem[XLEN-1:2] : addr_q[XLEN-1:2])) begin
                    valid_q <= 1'b0;
                end
                if ((fsm == BUSY) && !capture && (load_addr[XLEN-1:2] == pc_imem[XLEN-1:2])) begin
                    wait_cnt <= WS_START;
                end
            end
        end
    end

endmodule
